// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port word RAM serving fetch and load/store channels one at a time
// with programmable request-accept and response latencies.
module mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int REQ_LAT    = 1,
    parameter int RESP_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Counters are loaded with LAT-1 so that a zero count means "leave on this cycle".
    localparam logic [3:0] REQ_LOAD  = (REQ_LAT  > 0) ? 4'(REQ_LAT  - 1) : 4'd0;
    localparam logic [3:0] RESP_LOAD = (RESP_LAT > 0) ? 4'(RESP_LAT - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_WAIT,
        S_ACK,
        S_RESP_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        CH_INST,
        CH_LOAD,
        CH_STORE
    } chan_e;

    state_e                  state_q, state_d;
    chan_e                   chan_q, chan_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             instr_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    req_live;
    logic                    resp_ack;
    logic                    mem_we;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic                    unused_bits;

    // Byte offset and bits beyond the RAM depth are dropped, so addresses wrap.
    assign unused_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0], Address[31:ADDR_WIDTH+2], Address[1:0]};
    assign wr_idx      = Address[ADDR_WIDTH+1:2];

    always_comb begin
        req_live = 1'b0;
        case (chan_q)
            CH_INST:  req_live = Inst_Req_Valid;
            CH_LOAD:  req_live = MemRead;
            CH_STORE: req_live = MemWrite;
            default:  req_live = 1'b0;
        endcase
    end

    assign resp_ack = (chan_q == CH_INST) ? Inst_Ack : Read_data_Ack;

    // A load going straight from ACK to RESP reads with the live Address of the ACK cycle.
    always_comb begin
        if (chan_q == CH_INST) begin
            rd_idx = pc_q;
        end else if (state_q == S_ACK) begin
            rd_idx = Address[ADDR_WIDTH+1:2];
        end else begin
            rd_idx = addr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        mem_we  = 1'b0;
        rd_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MemWrite || MemRead || Inst_Req_Valid) begin
                    if (MemWrite) begin
                        chan_d = CH_STORE;
                    end else if (MemRead) begin
                        chan_d = CH_LOAD;
                    end else begin
                        chan_d = CH_INST;
                        pc_d   = PC[ADDR_WIDTH+1:2];
                    end
                    cnt_d   = REQ_LOAD;
                    state_d = (REQ_LAT == 0) ? S_ACK : S_REQ_WAIT;
                end
            end

            S_REQ_WAIT: begin
                if (!req_live) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_ACK: begin
                if (!req_live) begin
                    state_d = S_IDLE;
                end else if (chan_q == CH_STORE) begin
                    mem_we  = !rst;
                    state_d = S_IDLE;
                end else begin
                    addr_d = Address[ADDR_WIDTH+1:2];
                    if (RESP_LAT == 0) begin
                        rd_en   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = RESP_LOAD;
                        state_d = S_RESP_WAIT;
                    end
                end
            end

            S_RESP_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rd_en   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_RESP: begin
                if (resp_ack) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            chan_q  <= CH_INST;
            cnt_q   <= 4'd0;
            pc_q    <= '0;
            addr_q  <= '0;
            instr_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            if (rd_en) begin
                if (chan_q == CH_INST) begin
                    instr_q <= mem_q[rd_idx];
                end else begin
                    rdata_q <= mem_q[rd_idx];
                end
            end
        end
    end

    // RAM contents survive reset; only the byte lanes enabled by Write_strb change.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (Write_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= Write_data[8*b +: 8];
                end
            end
        end
    end

    assign Inst_Req_Ack    = (state_q == S_ACK) && (chan_q == CH_INST) && req_live;
    assign Mem_Req_Ack     = (state_q == S_ACK) && (chan_q != CH_INST) && req_live;
    assign Inst_Valid      = (state_q == S_RESP) && (chan_q == CH_INST);
    assign Read_data_Valid = (state_q == S_RESP) && (chan_q != CH_INST);
    assign Instruction     = instr_q;
    assign Read_data       = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - bench for mem_responder: instance 0 uses latencies 1/2, instance 1 uses 0/0.
module tb_mem_responder;

    localparam int K_ST = 0;
    localparam int K_LD = 1;
    localparam int K_IF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_s [2];
    logic [31:0] addr_s [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  strb_s [2];
    logic        ireq_s [2];
    logic        iack_s [2];
    logic        mw_s [2];
    logic        mr_s [2];
    logic        rack_s [2];
    logic        ireq_ack_o [2];
    logic        ivalid_o [2];
    logic        mreq_ack_o [2];
    logic        rvalid_o [2];
    logic [31:0] instr_o [2];
    logic [31:0] rdata_o [2];

    int          total = 0;
    int          bad = 0;
    int          ack_lat [2];
    int          vld_lat [2];
    logic [31:0] model [2][4096];
    logic [31:0] exp_q [$];
    bit          watch = 1'b0;
    int          iack_early = 0;

    typedef struct {
        int          d;
        int          kind;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  sb;
        int          hold;
        bit          use_exp;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(12), .REQ_LAT(1), .RESP_LAT(2)) dut0 (
        .clk(clk), .rst(rst),
        .PC(pc_s[0]), .Inst_Req_Valid(ireq_s[0]), .Inst_Req_Ack(ireq_ack_o[0]),
        .Instruction(instr_o[0]), .Inst_Valid(ivalid_o[0]), .Inst_Ack(iack_s[0]),
        .Address(addr_s[0]), .MemWrite(mw_s[0]), .Write_data(wdata_s[0]), .Write_strb(strb_s[0]),
        .MemRead(mr_s[0]), .Mem_Req_Ack(mreq_ack_o[0]), .Read_data(rdata_o[0]),
        .Read_data_Valid(rvalid_o[0]), .Read_data_Ack(rack_s[0])
    );

    mem_responder #(.ADDR_WIDTH(12), .REQ_LAT(0), .RESP_LAT(0)) dut1 (
        .clk(clk), .rst(rst),
        .PC(pc_s[1]), .Inst_Req_Valid(ireq_s[1]), .Inst_Req_Ack(ireq_ack_o[1]),
        .Instruction(instr_o[1]), .Inst_Valid(ivalid_o[1]), .Inst_Ack(iack_s[1]),
        .Address(addr_s[1]), .MemWrite(mw_s[1]), .Write_data(wdata_s[1]), .Write_strb(strb_s[1]),
        .MemRead(mr_s[1]), .Mem_Req_Ack(mreq_ack_o[1]), .Read_data(rdata_o[1]),
        .Read_data_Valid(rvalid_o[1]), .Read_data_Ack(rack_s[1])
    );

    always @(negedge clk) begin
        if (watch && ireq_ack_o[0]) iack_early = iack_early + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input int d, input string name);
        chk({name, "_flags"}, {28'd0, ireq_ack_o[d], ivalid_o[d], mreq_ack_o[d], rvalid_o[d]}, 32'd0);
        chk({name, "_instr"}, instr_o[d], 32'd0);
        chk({name, "_rdata"}, rdata_o[d], 32'd0);
    endtask

    function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
        return model[d][a[13:2]];
    endfunction

    // Called at posedge+1 during an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic txn(input int d, input int kind, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] sb, input int hold, input logic [31:0] exp);
        int          cyc;
        bit          got;
        logic [31:0] e;
        logic [31:0] act;
        if (kind == K_ST) begin
            for (int b = 0; b < 4; b++)
                if (sb[b]) model[d][a[13:2]][8*b +: 8] = wd[8*b +: 8];
            addr_s[d] = a; wdata_s[d] = wd; strb_s[d] = sb; mw_s[d] = 1'b1;
        end else if (kind == K_LD) begin
            exp_q.push_back(exp);
            addr_s[d] = a; mr_s[d] = 1'b1;
        end else begin
            exp_q.push_back(exp);
            pc_s[d] = a; ireq_s[d] = 1'b1;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if ((kind == K_IF) ? ireq_ack_o[d] : mreq_ack_o[d]) got = 1'b1;
            else cyc++;
        end
        chk("ack_latency", got ? cyc : -1, ack_lat[d]);
        @(posedge clk); #1;
        mw_s[d] = 1'b0; mr_s[d] = 1'b0; ireq_s[d] = 1'b0;
        if (kind != K_ST) begin
            got = 1'b0;
            while (!got && cyc < 80) begin
                @(negedge clk);
                cyc++;
                if ((kind == K_IF) ? ivalid_o[d] : rvalid_o[d]) got = 1'b1;
            end
            chk("valid_latency", got ? cyc : -1, vld_lat[d]);
            e   = exp_q.pop_front();
            act = (kind == K_IF) ? instr_o[d] : rdata_o[d];
            chk("resp_data", act, e);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("hold_valid", (kind == K_IF) ? ivalid_o[d] : rvalid_o[d], 1);
                chk("hold_data", (kind == K_IF) ? instr_o[d] : rdata_o[d], e);
            end
            @(posedge clk); #1;
            if (kind == K_IF) iack_s[d] = 1'b1; else rack_s[d] = 1'b1;
            @(negedge clk);
            chk("valid_at_ack", (kind == K_IF) ? ivalid_o[d] : rvalid_o[d], 1);
            @(posedge clk); #1;
            iack_s[d] = 1'b0; rack_s[d] = 1'b0;
            chk("valid_drop", (kind == K_IF) ? ivalid_o[d] : rvalid_o[d], 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        bit          got;
        logic [31:0] e;
        ack_lat[0] = 2; vld_lat[0] = 5;
        ack_lat[1] = 1; vld_lat[1] = 2;
        for (int d = 0; d < 2; d++) begin
            pc_s[d] = 0; addr_s[d] = 0; wdata_s[d] = 0; strb_s[d] = 0;
            ireq_s[d] = 0; iack_s[d] = 0; mw_s[d] = 0; mr_s[d] = 0;
        end
        // An idle requester holding its response Ack high must be ignored.
        rack_s[0] = 1'b1; rack_s[1] = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst = 1'b0;
        @(posedge clk); #1;
        rack_s[0] = 1'b0;

        tbl.push_back('{0, K_ST, 32'h10,   32'h00A00093, 4'hF, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_IF, 32'h10,   32'h0,        4'h0, 3, 1'b1, 32'h00A00093});
        tbl.push_back('{0, K_ST, 32'h20,   32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_ST, 32'h20,   32'h00550000, 4'h4, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_LD, 32'h20,   32'h0,        4'h0, 0, 1'b1, 32'hDE55BEEF});
        tbl.push_back('{0, K_ST, 32'h4000, 32'h12345678, 4'hF, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_LD, 32'h0,    32'h0,        4'h0, 0, 1'b1, 32'h12345678});
        tbl.push_back('{0, K_ST, 32'h24,   32'h11223344, 4'hF, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_ST, 32'h24,   32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_LD, 32'h24,   32'h0,        4'h0, 0, 1'b1, 32'h11223344});
        tbl.push_back('{0, K_ST, 32'h43,   32'hAAAA5555, 4'hF, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_LD, 32'h40,   32'h0,        4'h0, 1, 1'b1, 32'hAAAA5555});
        tbl.push_back('{0, K_ST, 32'h28,   32'h00000000, 4'hF, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_ST, 32'h28,   32'hCAFEF00D, 4'h9, 0, 1'b0, 32'h0});
        tbl.push_back('{0, K_LD, 32'h28,   32'h0,        4'h0, 2, 1'b1, 32'hCA00000D});
        for (int i = 0; i < 10; i++)
            tbl.push_back('{1, K_ST, 32'h100 + 32'(4*i), 32'h0F000000 + 32'(i*32'h11111), 4'hF, 0, 1'b0, 32'h0});

        foreach (tbl[i]) begin
            e = tbl[i].use_exp ? tbl[i].exp : model_rd(tbl[i].d, tbl[i].a);
            txn(tbl[i].d, tbl[i].kind, tbl[i].a, tbl[i].wd, tbl[i].sb, tbl[i].hold, e);
        end

        // Ten back-to-back fetches on the zero-latency instance.
        for (int i = 0; i < 10; i++)
            txn(1, K_IF, 32'h100 + 32'(4*i), 32'h0, 4'h0, 0, model_rd(1, 32'h100 + 32'(4*i)));

        // Load and fetch requested together: load first, fetch held off until after its handshake.
        pc_s[0] = 32'h10; ireq_s[0] = 1'b1;
        iack_early = 0; watch = 1'b1;
        txn(0, K_LD, 32'h20, 32'h0, 4'h0, 0, 32'hDE55BEEF);
        watch = 1'b0;
        chk("fetch_held_off", iack_early, 0);
        txn(0, K_IF, 32'h10, 32'h0, 4'h0, 0, 32'h00A00093);

        // MemRead with MemWrite is a store only: no read response follows.
        mr_s[0] = 1'b1;
        txn(0, K_ST, 32'h2C, 32'h5A5A1234, 4'hF, 0, 32'h0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid_o[0] || mreq_ack_o[0]) n++;
        end
        chk("rw_store_only", n, 0);
        @(posedge clk); #1;
        txn(0, K_LD, 32'h2C, 32'h0, 4'h0, 0, 32'h5A5A1234);

        // Reset during RESP_WAIT of a load.
        addr_s[0] = 32'h10; mr_s[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = mreq_ack_o[0];
        end
        chk("rst_load_ack", got, 1);
        @(posedge clk); #1;
        mr_s[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero(0, "rst_resp_wait");
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid_o[0]) n++;
        end
        chk("rst_no_resp", n, 0);
        @(posedge clk); #1;

        // Reset during REQ_WAIT of a store to 0x40: the write must never land.
        addr_s[0] = 32'h40; wdata_s[0] = 32'h99999999; strb_s[0] = 4'hF; mw_s[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mw_s[0] = 1'b0;
        rst = 1'b0;
        chk_zero(0, "rst_req_wait");
        @(posedge clk); #1;
        txn(0, K_LD, 32'h40, 32'h0, 4'h0, 0, 32'hAAAA5555);
        txn(0, K_LD, 32'h10, 32'h0, 4'h0, 0, 32'h00A00093);
        txn(0, K_IF, 32'h10, 32'h0, 4'h0, 0, 32'h00A00093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's two request/response channel pairs: instruction fetch, and data load/store.
- Holds a single-port word-organised RAM.
- Serves one transaction at a time with programmable request-accept and response latencies, so the multi-cycle core's handshakes can be exercised under stall.
- Sits between the core and the simulation/board memory wrapper.

Parameters:
- ADDR_WIDTH, 12, number of word-address bits; RAM depth = 2^ADDR_WIDTH words of 32 bits.
- REQ_LAT, 1, extra idle cycles between request detection and Ack (0..15).
- RESP_LAT, 2, extra idle cycles between Ack and response Valid (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- PC  in  32  instruction fetch address
- Inst_Req_Valid  in  1  fetch request
- Inst_Req_Ack  out  1  fetch request accepted
- Instruction  out  32  fetched word
- Inst_Valid  out  1  Instruction valid
- Inst_Ack  in  1  requester accepts Instruction
- Address  in  32  data address (word aligned by requester)
- MemWrite  in  1  store request
- Write_data  in  32  store data
- Write_strb  in  4  byte enables, bit i -> byte i
- MemRead  in  1  load request
- Mem_Req_Ack  out  1  data request accepted
- Read_data  out  32  load data
- Read_data_Valid  out  1  Read_data valid
- Read_data_Ack  in  1  requester accepts Read_data

Behaviour:
- Reset: synchronous reset, active-high, rst; clock clk. All outputs 0 the cycle after rst is sampled high; state IDLE; counters 0; RAM contents not cleared.
- Reset mid-operation: transaction dropped; a store not yet in ACK is never written.
- FSM states: IDLE, REQ_WAIT, ACK, RESP_WAIT, RESP.
- IDLE: sample requests.
  - Priority: MemWrite > MemRead > Inst_Req_Valid.
  - Latch channel (INST/LOAD/STORE) and, for INST, PC.
  - Go to REQ_WAIT with cnt=REQ_LAT, or directly to ACK if REQ_LAT=0.
- REQ_WAIT: decrement cnt; at 0 go to ACK.
  - If the latched channel's request drops, abort to IDLE.
- ACK: assert Inst_Req_Ack (INST) or Mem_Req_Ack (LOAD/STORE) for exactly one cycle.
  - Address, Write_data and Write_strb are sampled in this cycle (data channel).
  - STORE: RAM word Address[ADDR_WIDTH+1:2] written under Write_strb; next state IDLE; no response phase.
  - If the request is low in ACK: no handshake, return to IDLE.
- RESP_WAIT: count RESP_LAT, skipped if 0. RAM read performed on entry to RESP; result registered into Instruction or Read_data.
- RESP: hold Inst_Valid or Read_data_Valid high with stable data until the matching Inst_Ack or Read_data_Ack is seen high; valid drops the next cycle and state returns to IDLE.
  - Ack high while valid is low is ignored (e.g. an Ack held high by an idle requester).
- Latency, request first seen at cycle T:
  - Ack at T+1+REQ_LAT.
  - Valid at T+2+REQ_LAT+RESP_LAT.
  - Back-to-back: next request sampled in IDLE the cycle after the response handshake.
- Address rules:
  - Address/PC bits above ADDR_WIDTH+1 ignored (wrap-around); bits [1:0] ignored.
  - Write_strb=0 in a store: handshake completes, RAM unchanged.
- MemRead and MemWrite high together: treated as STORE only.
- Only one outstanding transaction; requests arriving while busy wait in their own valid.

Test Plan:
- Fetch, REQ_LAT=1, RESP_LAT=2, RAM[4]=0x00A00093, PC=0x10 asserted at T -> Inst_Req_Ack at T+2 only; Inst_Valid at T+5 with Instruction=0x00A00093; held while Inst_Ack=0; drops the cycle after Inst_Ack=1.
- Store then load: sw 0xDEADBEEF strb=1111 at 0x20, then sb 0x55 strb=0100 at 0x20, then load 0x20 -> Read_data=0xDE55BEEF.
- Simultaneous MemRead and Inst_Req_Valid in IDLE -> Mem_Req_Ack first; fetch acked only after Read_data handshake.
- REQ_LAT=0, RESP_LAT=0 -> Ack at T+1, Valid at T+2; 10 back-to-back fetches with PC+=4 return consecutive RAM words.
- rst asserted during RESP_WAIT of a load, and again in REQ_WAIT of a store to 0x40 -> all outputs 0 next cycle; RAM[0x10] unchanged; next fetch proceeds normally.
- Address 0x4000 with ADDR_WIDTH=12, store 0x12345678 -> read of address 0x0 returns 0x12345678.
